// File: rtl/io_pkg.sv
// Shared types and default timing constants for the board-input front end.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    // 10 ms at 50 MHz, and a 0.5 s auto-repeat period
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 25000000;

endpackage

// File: rtl/io_input_conditioner_if.sv
// Raw board pins in, conditioned processor-side strobes and levels out.
interface io_input_conditioner_if #(
    parameter int unsigned SW_WIDTH = 10
);

    logic                button0;
    logic                button1;
    logic [SW_WIDTH-1:0] switches;
    logic                port0_en;
    logic                port1_en;
    logic                btn0_level;
    logic                btn1_level;
    logic [SW_WIDTH-1:0] switches_out;

    modport master (
        output button0, button1, switches,
        input  port0_en, port1_en, btn0_level, btn1_level, switches_out
    );

    modport slave (
        input  button0, button1, switches,
        output port0_en, port1_en, btn0_level, btn1_level, switches_out
    );

endinterface

// File: rtl/button_debouncer.sv
// Synchronizer + press/release qualification FSM for one active-low pushbutton.
// Optional auto-repeat of the press pulse when BTN_AUTOREPEAT_EN is defined.
module button_debouncer
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
    , parameter int unsigned REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic sync1, s;

    // Synchronizer resets to the released level so reset never looks like a press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    btn_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept;
    logic             pulse_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = HELD;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!s) begin
                    state_next = HELD;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned     RPT_W   = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rcnt, rcnt_next;
    logic             repeat_hit;

    // A release bounce back to HELD keeps the repeat phase; only acceptance or IDLE clears it
    always_comb begin
        rcnt_next  = rcnt;
        repeat_hit = 1'b0;
        if (state == HELD || state == RELEASE_WAIT) begin
            if (rcnt == RPT_MAX) begin
                repeat_hit = 1'b1;
                rcnt_next  = '0;
            end else begin
                rcnt_next = rcnt + RPT_W'(1);
            end
        end
        if (accept || state_next == IDLE) begin
            rcnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rcnt <= '0;
        else      rcnt <= rcnt_next;
    end

    assign pulse_next = accept | repeat_hit;
`else
    assign pulse_next = accept;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pulse <= pulse_next;
            level <= (state_next == HELD) || (state_next == RELEASE_WAIT);
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Synchronizes and debounces two pushbuttons and the slide switches ahead of the processor.
// BTN_AUTOREPEAT_EN enables auto-repeat of the button load pulses.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned SW_WIDTH        = 10,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input logic clk,
    input logic rst,
    io_input_conditioner_if.slave bus
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("io_input_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    logic p0, p1, l0, l1;

`ifdef BTN_AUTOREPEAT_EN
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_btn0 (
        .clk(clk), .rst(rst), .raw(bus.button0), .pulse(p0), .level(l0)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_btn1 (
        .clk(clk), .rst(rst), .raw(bus.button1), .pulse(p1), .level(l1)
    );
`else
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
        .clk(clk), .rst(rst), .raw(bus.button0), .pulse(p0), .level(l0)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
        .clk(clk), .rst(rst), .raw(bus.button1), .pulse(p1), .level(l1)
    );
`endif

    assign bus.port0_en   = p0;
    assign bus.port1_en   = p1;
    assign bus.btn0_level = l0;
    assign bus.btn1_level = l1;

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sw_sync1, sw_s, cand, sw_out;
    logic [CNT_W-1:0]    scnt;

    // One shared qualifier: any bit change restarts the whole vector's stability window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_sync1 <= '0;
            sw_s     <= '0;
            cand     <= '0;
            scnt     <= '0;
            sw_out   <= '0;
        end else begin
            sw_sync1 <= bus.switches;
            sw_s     <= sw_sync1;
            if (sw_s != cand) begin
                cand <= sw_s;
                scnt <= '0;
            end else if (scnt == CNT_MAX) begin
                sw_out <= cand;
            end else begin
                scnt <= scnt + CNT_W'(1);
            end
        end
    end

    assign bus.switches_out = sw_out;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed timing scenarios plus random bouncing inputs
// checked against a run-length reference model. Honours BTN_AUTOREPEAT_EN.
module tb_io_input_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned REP = 8;
    localparam int unsigned SW  = 10;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_input_conditioner_if #(.SW_WIDTH(SW)) bus ();

    io_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .SW_WIDTH(SW),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a level flips once the synchronized pin has disagreed with it
    // for DEB+1 consecutive samples; switches follow DEB+1 identical samples.
    logic [1:0]    m_s1, m_s2, m_level, m_pulse;
    int            m_run [2];
    int            m_rep [2];
    logic [SW-1:0] m_sw1, m_sw2, m_sw_out;
    logic [SW-1:0] m_hist [$];

    task automatic model_reset();
        m_s1 = 2'b11; m_s2 = 2'b11; m_level = '0; m_pulse = '0;
        for (int b = 0; b < 2; b++) begin m_run[b] = 0; m_rep[b] = 0; end
        m_sw1 = '0; m_sw2 = '0; m_sw_out = '0;
        m_hist.delete();
        for (int i = 0; i < DEB + 1; i++) m_hist.push_back('0);
    endtask

    task automatic model_step();
        logic [1:0] raw;
        bit same;
        raw = {bus.button1, bus.button0};
        if (!rst) begin
            model_reset();
            return;
        end
        for (int b = 0; b < 2; b++) begin
            m_pulse[b] = 1'b0;
            if (m_level[b]) begin
                m_rep[b]++;
                if (m_rep[b] == REP) begin m_rep[b] = 0; m_pulse[b] = AUTOREPEAT; end
            end
            if (m_s2[b] == m_level[b]) m_run[b]++;
            else m_run[b] = 0;
            if (m_run[b] == DEB + 1) begin
                m_level[b] = ~m_level[b];
                m_run[b] = 0;
                m_rep[b] = 0;
                if (m_level[b]) m_pulse[b] = 1'b1;
            end
        end
        m_s2 = m_s1; m_s1 = raw;
        m_hist.push_back(m_sw2);
        if (m_hist.size() > DEB + 1) void'(m_hist.pop_front());
        same = 1'b1;
        for (int i = 1; i < m_hist.size(); i++) if (m_hist[i] !== m_hist[0]) same = 1'b0;
        if (same) m_sw_out = m_hist[0];
        m_sw2 = m_sw1; m_sw1 = bus.switches;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic settle();
        bus.button0 = 1'b1; bus.button1 = 1'b1; bus.switches = '0;
        repeat (14) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.port0_en, bus.port1_en, bus.btn0_level, bus.btn1_level, bus.switches_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b_%b_%b_%b_%h want all zero",
                     bus.port0_en, bus.port1_en, bus.btn0_level, bus.btn1_level, bus.switches_out);
        end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.port0_en, bus.port1_en, bus.btn0_level, bus.btn1_level, bus.switches_out} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b_%b_%b_%b_%h want all zero",
                     bus.port0_en, bus.port1_en, bus.btn0_level, bus.btn1_level, bus.switches_out);
        end
    endtask

    task automatic test_clean_press();
        settle();
        bus.button0 = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if ({bus.port0_en, bus.btn0_level, bus.port1_en, bus.btn1_level} !== {(n == 7), (n >= 7), 2'b00}) begin
                errors++;
                $display("FAIL clean_press edge %0d: p0/l0/p1/l1 got %b%b%b%b want %b%b00", n,
                         bus.port0_en, bus.btn0_level, bus.port1_en, bus.btn1_level, (n == 7), (n >= 7));
            end
        end
    endtask

    task automatic test_release();
        settle();
        bus.button0 = 1'b0;
        repeat (8) tick();
        for (int n = 1; n <= 14; n++) begin
            bus.button0 = (n == 3 || n == 4) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (bus.btn0_level !== (n < 11)) begin
                errors++;
                $display("FAIL release_level edge %0d: got %b want %b", n, bus.btn0_level, (n < 11));
            end
            checks++;
            if (bus.port0_en !== m_pulse[0]) begin
                errors++;
                $display("FAIL release_pulse edge %0d: got %b want %b", n, bus.port0_en, m_pulse[0]);
            end
        end
    endtask

    task automatic test_bounce_press();
        settle();
        for (int n = 1; n <= 14; n++) begin
            bus.button0 = (n <= 4) ? (n % 2 == 0) : 1'b0;
            tick();
            checks++;
            if ({bus.port0_en, bus.btn0_level} !== {(n == 11), (n >= 11)}) begin
                errors++;
                $display("FAIL bounce_press edge %0d: p0/l0 got %b%b want %b%b", n,
                         bus.port0_en, bus.btn0_level, (n == 11), (n >= 11));
            end
        end
    endtask

    task automatic test_switches_simul();
        logic [SW-1:0] exp_sw;
        settle();
        bus.button0 = 1'b0; bus.button1 = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            bus.switches = (n == 3) ? 10'h2A4 : 10'h2A5;
            tick();
            exp_sw = (n >= 10) ? 10'h2A5 : 10'h000;
            checks++;
            if ({bus.port0_en, bus.port1_en, bus.switches_out} !== {(n == 7), (n == 7), exp_sw}) begin
                errors++;
                $display("FAIL switches_simul edge %0d: p0/p1/sw got %b%b/%h want %b%b/%h", n,
                         bus.port0_en, bus.port1_en, bus.switches_out, (n == 7), (n == 7), exp_sw);
            end
        end
    endtask

    task automatic test_reset_mid();
        settle();
        bus.button0 = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.port0_en, bus.port1_en, bus.btn0_level, bus.btn1_level, bus.switches_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b_%b_%b_%b_%h want all zero",
                     bus.port0_en, bus.port1_en, bus.btn0_level, bus.btn1_level, bus.switches_out);
        end
        repeat (3) tick();
        rst = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if ({bus.port0_en, bus.btn0_level} !== {(n == 7), (n >= 7)}) begin
                errors++;
                $display("FAIL reset_requalify edge %0d: p0/l0 got %b%b want %b%b", n,
                         bus.port0_en, bus.btn0_level, (n == 7), (n >= 7));
            end
        end
    endtask

    task automatic test_autorepeat();
        logic exp_p;
        settle();
        bus.button1 = 1'b0;
        for (int n = 1; n <= 38; n++) begin
            tick();
            exp_p = AUTOREPEAT ? (n == 7 || n == 15 || n == 23 || n == 31) : (n == 7);
            checks++;
            if ({bus.port1_en, bus.port0_en} !== {exp_p, 1'b0}) begin
                errors++;
                $display("FAIL autorepeat edge %0d: p1/p0 got %b%b want %b0", n,
                         bus.port1_en, bus.port0_en, exp_p);
            end
        end
    endtask

    task automatic test_random();
        int            hold [3];
        logic [13:0]   got, want;
        settle();
        for (int i = 0; i < 3; i++) hold[i] = 0;
        for (int n = 0; n < 900; n++) begin
            if (hold[0] == 0) begin bus.button0 = 1'($urandom_range(0, 1)); hold[0] = $urandom_range(1, 10); end
            if (hold[1] == 0) begin bus.button1 = 1'($urandom_range(0, 1)); hold[1] = $urandom_range(1, 10); end
            if (hold[2] == 0) begin
                bus.switches = ($urandom_range(0, 3) == 0) ? (bus.switches ^ SW'(1 << $urandom_range(0, SW - 1)))
                                                         : SW'($urandom);
                hold[2] = $urandom_range(1, 12);
            end
            for (int i = 0; i < 3; i++) hold[i]--;
            tick();
            got  = {bus.port1_en, bus.port0_en, bus.btn1_level, bus.btn0_level, bus.switches_out};
            want = {m_pulse[1], m_pulse[0], m_level[1], m_level[0], m_sw_out};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random cycle %0d: p1p0l1l0_sw got %b want %b", n, got, want);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.button0 = 1'b1;
        bus.button1 = 1'b1;
        bus.switches = '0;
        model_reset();
        test_reset();
        test_clean_press();
        test_release();
        test_bounce_press();
        test_switches_simul();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
